// File: rtl/sargantana_icache_refill.sv
// Instruction-cache refill sequencer: collects line beats, picks a victim way, writes the line.
// Optional ICACHE_REFILL_LFSR_EN selects an LFSR victim instead of the round-robin pointer.
module sargantana_icache_refill #(
  parameter int unsigned ICACHE_N_WAY = 4,
  parameter int unsigned SET_WIDHT    = 256,
  parameter int unsigned BEAT_WIDHT   = 64,
  parameter int unsigned TAG_WIDHT    = 20,
  parameter int unsigned ADDR_WIDHT   = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    refill_req_i,
  output logic                    refill_ready_o,
  input  logic [TAG_WIDHT-1:0]    refill_tag_i,
  input  logic [ADDR_WIDHT-1:0]   refill_idx_i,
  input  logic                    beat_valid_i,
  input  logic [BEAT_WIDHT-1:0]   beat_data_i,
  input  logic                    flush_i,
  output logic                    refill_done_o,
  output logic                    busy_o,
  output logic [ICACHE_N_WAY-1:0] tag_req_o,
  output logic [ICACHE_N_WAY-1:0] data_req_o,
  output logic                    tag_we_o,
  output logic                    data_we_o,
  output logic                    flush_en_o,
  output logic                    valid_bit_o,
  output logic [SET_WIDHT-1:0]    cline_o,
  output logic [TAG_WIDHT-1:0]    tag_o,
  output logic [ADDR_WIDHT-1:0]   addr_o
);

  localparam int unsigned Beats = SET_WIDHT / BEAT_WIDHT;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned WayW  = $clog2(ICACHE_N_WAY);
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StFlush = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [SET_WIDHT-1:0]  line_q, line_d;
  logic [TAG_WIDHT-1:0]  tag_q, tag_d;
  logic [ADDR_WIDHT-1:0] idx_q, idx_d;
  logic [WayW-1:0]       victim_q, victim_d;
  logic [WayW-1:0]       victim_pick;

`ifdef ICACHE_REFILL_LFSR_EN
  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free-running every cycle
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign victim_pick = lfsr_q[WayW-1:0];
`else
  logic [WayW-1:0] rr_q, rr_d;

  // Pointer only moves when a line is actually written
  always_comb begin
    rr_d = rr_q;
    if (state_q == StWrite) begin
      rr_d = rr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign victim_pick = rr_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    tag_d    = tag_q;
    idx_d    = idx_q;
    victim_d = victim_q;
    case (state_q)
      StIdle: begin
        if (flush_i) begin
          state_d = StFlush;
        end else if (refill_req_i) begin
          tag_d    = refill_tag_i;
          idx_d    = refill_idx_i;
          victim_d = victim_pick;
          cnt_d    = '0;
          state_d  = StFill;
        end
      end
      StFill: begin
        if (flush_i) begin
          // Abandon the refill; partial line is discarded
          cnt_d   = '0;
          line_d  = '0;
          state_d = StFlush;
        end else if (beat_valid_i) begin
          for (int unsigned b = 0; b < Beats; b++) begin
            if (cnt_q == CntW'(b)) begin
              line_d[b*BEAT_WIDHT +: BEAT_WIDHT] = beat_data_i;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        state_d = flush_i ? StFlush : StIdle;
      end
      default: begin
        state_d = flush_i ? StFlush : StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      line_q   <= '0;
      tag_q    <= '0;
      idx_q    <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      victim_q <= victim_d;
    end
  end

  logic [ICACHE_N_WAY-1:0] way_oh;
  assign way_oh = {{(ICACHE_N_WAY-1){1'b0}}, 1'b1} << victim_q;

  // Memory-side outputs decode registered state only
  always_comb begin
    refill_ready_o = (state_q == StIdle);
    busy_o         = (state_q != StIdle);
    refill_done_o  = 1'b0;
    tag_req_o      = '0;
    data_req_o     = '0;
    tag_we_o       = 1'b0;
    data_we_o      = 1'b0;
    flush_en_o     = 1'b0;
    valid_bit_o    = 1'b0;
    case (state_q)
      StWrite: begin
        tag_req_o     = way_oh;
        data_req_o    = way_oh;
        tag_we_o      = 1'b1;
        data_we_o     = 1'b1;
        valid_bit_o   = 1'b1;
        refill_done_o = 1'b1;
      end
      StFlush: begin
        flush_en_o = 1'b1;
        tag_req_o  = '1;
        tag_we_o   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign cline_o = line_q;
  assign tag_o   = tag_q;
  assign addr_o  = idx_q;

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// Directed bench for sargantana_icache_refill: table of refills plus flush/reset corner sequences.
module tb_sargantana_icache_refill;

  logic          clk;
  logic          rst;
  logic          refill_req_i;
  logic          refill_ready_o;
  logic [19:0]   refill_tag_i;
  logic [5:0]    refill_idx_i;
  logic          beat_valid_i;
  logic [63:0]   beat_data_i;
  logic          flush_i;
  logic          refill_done_o;
  logic          busy_o;
  logic [3:0]    tag_req_o;
  logic [3:0]    data_req_o;
  logic          tag_we_o;
  logic          data_we_o;
  logic          flush_en_o;
  logic          valid_bit_o;
  logic [255:0]  cline_o;
  logic [19:0]   tag_o;
  logic [5:0]    addr_o;

  sargantana_icache_refill dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .refill_req_i   (refill_req_i),
    .refill_ready_o (refill_ready_o),
    .refill_tag_i   (refill_tag_i),
    .refill_idx_i   (refill_idx_i),
    .beat_valid_i   (beat_valid_i),
    .beat_data_i    (beat_data_i),
    .flush_i        (flush_i),
    .refill_done_o  (refill_done_o),
    .busy_o         (busy_o),
    .tag_req_o      (tag_req_o),
    .data_req_o     (data_req_o),
    .tag_we_o       (tag_we_o),
    .data_we_o      (data_we_o),
    .flush_en_o     (flush_en_o),
    .valid_bit_o    (valid_bit_o),
    .cline_o        (cline_o),
    .tag_o          (tag_o),
    .addr_o         (addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ICACHE_REFILL_LFSR_EN
  logic [7:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 8'h01;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
`endif

  typedef struct {
    logic [5:0]   idx;
    logic [19:0]  tag;
    logic [255:0] line;
    logic         gap;
    logic         fl_w;
    logic [3:0]   exp_oh;
  } vec_t;

  vec_t vecs [6];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk_b({name, "_ready"}, refill_ready_o, 1'b1);
    chk_b({name, "_busy"}, busy_o, 1'b0);
    chk_b({name, "_done"}, refill_done_o, 1'b0);
    chk_b({name, "_tag_we"}, tag_we_o, 1'b0);
    chk_b({name, "_flush_en"}, flush_en_o, 1'b0);
  endtask

  task automatic chk_flush(input string name);
    chk_b({name, "_flush_en"}, flush_en_o, 1'b1);
    chk_v({name, "_tag_req"}, 256'(tag_req_o), 256'(4'b1111));
    chk_b({name, "_tag_we"}, tag_we_o, 1'b1);
    chk_b({name, "_valid"}, valid_bit_o, 1'b0);
    chk_v({name, "_data_req"}, 256'(data_req_o), 256'(4'b0000));
    chk_b({name, "_data_we"}, data_we_o, 1'b0);
    chk_b({name, "_done"}, refill_done_o, 1'b0);
  endtask

  // Entered and left at a negedge, so consecutive calls are back-to-back refills.
  task automatic refill(input vec_t v);
    logic [3:0] exp_oh;
    chk_b("accept_ready", refill_ready_o, 1'b1);
    refill_req_i = 1'b1;
    refill_tag_i = v.tag;
    refill_idx_i = v.idx;
`ifdef ICACHE_REFILL_LFSR_EN
    exp_oh = 4'b0001 << m_lfsr[1:0];
`else
    exp_oh = v.exp_oh;
`endif
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      refill_req_i = 1'b0;
      beat_valid_i = 1'b0;
      chk_b("fill_busy", busy_o, 1'b1);
      chk_b("fill_done", refill_done_o, 1'b0);
      if (v.gap) begin
        @(negedge clk);
        chk_b("gap_tag_we", tag_we_o, 1'b0);
      end
      beat_valid_i = 1'b1;
      beat_data_i  = v.line[b*64 +: 64];
    end
    @(negedge clk);
    beat_valid_i = 1'b0;
    chk_b("write_done", refill_done_o, 1'b1);
    chk_b("write_tag_we", tag_we_o, 1'b1);
    chk_b("write_data_we", data_we_o, 1'b1);
    chk_b("write_valid", valid_bit_o, 1'b1);
    chk_b("write_flush_en", flush_en_o, 1'b0);
    chk_v("write_addr", 256'(addr_o), 256'(v.idx));
    chk_v("write_tag", 256'(tag_o), 256'(v.tag));
    chk_v("write_cline", cline_o, v.line);
    chk_v("write_tag_req", 256'(tag_req_o), 256'(exp_oh));
    chk_v("write_data_req", 256'(data_req_o), 256'(exp_oh));
    if (v.fl_w) begin
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk_flush("flush_after_write");
    end
    @(negedge clk);
    chk_idle("post_write");
  endtask

  initial begin
    vec_t hv;
    refill_req_i = 1'b0;
    refill_tag_i = '0;
    refill_idx_i = '0;
    beat_valid_i = 1'b0;
    beat_data_i  = '0;
    flush_i      = 1'b0;
    rst          = 1'b1;

    vecs[0] = '{6'd5,  20'hABCDE, {64'h4444444444444444, 64'h3333333333333333,
                64'h2222222222222222, 64'h1111111111111111}, 1'b0, 1'b0, 4'b0001};
    vecs[1] = '{6'd6,  20'h12345, {64'hDEADBEEF00000004, 64'hDEADBEEF00000003,
                64'hDEADBEEF00000002, 64'hDEADBEEF00000001}, 1'b1, 1'b0, 4'b0010};
    vecs[2] = '{6'd63, 20'hFFFFF, {64'hFFFFFFFFFFFFFFFF, 64'h0,
                64'hFFFFFFFFFFFFFFFF, 64'h0}, 1'b0, 1'b0, 4'b0100};
    vecs[3] = '{6'd0,  20'h00001, {64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A,
                64'h0123456789ABCDEF, 64'hFEDCBA9876543210}, 1'b1, 1'b0, 4'b1000};
    vecs[4] = '{6'd17, 20'h5A5A5, {64'h0000000100000001, 64'h0000000200000002,
                64'h0000000300000003, 64'h0000000400000004}, 1'b0, 1'b0, 4'b0001};
    vecs[5] = '{6'd9,  20'h0F0F0, {64'hCAFEF00DCAFEF00D, 64'h8badf00d8badf00d,
                64'h1234123412341234, 64'h9876987698769876}, 1'b0, 1'b1, 4'b0010};

    @(negedge clk);
    @(negedge clk);
    chk_idle("reset");
    chk_v("reset_tag_req", 256'(tag_req_o), 256'(4'b0000));
    chk_v("reset_data_req", 256'(data_req_o), 256'(4'b0000));
    chk_b("reset_data_we", data_we_o, 1'b0);
    chk_b("reset_valid", valid_bit_o, 1'b0);
    chk_v("reset_cline", cline_o, 256'(0));
    chk_v("reset_tag", 256'(tag_o), 256'(0));
    chk_v("reset_addr", 256'(addr_o), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) refill(vecs[i]);

    // Stray beats in IDLE must not touch the line
    beat_valid_i = 1'b1;
    beat_data_i  = 64'hBADBADBADBADBAD0;
    repeat (3) @(negedge clk);
    beat_valid_i = 1'b0;
    chk_b("stray_busy", busy_o, 1'b0);
    chk_v("stray_cline", cline_o, vecs[5].line);

    // Flush after two beats aborts the refill
    refill_req_i = 1'b1;
    refill_tag_i = 20'h77777;
    refill_idx_i = 6'd33;
    @(negedge clk);
    refill_req_i = 1'b0;
    beat_valid_i = 1'b1;
    beat_data_i  = 64'h1;
    @(negedge clk);
    beat_data_i  = 64'h2;
    @(negedge clk);
    beat_valid_i = 1'b0;
    flush_i      = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk_flush("abort_flush");
    @(negedge clk);
    chk_idle("abort_idle");

    // Victim pointer did not move on the aborted refill
    hv = '{6'd40, 20'h24680, {64'h0404040404040404, 64'h0303030303030303,
           64'h0202020202020202, 64'h0101010101010101}, 1'b0, 1'b0, 4'b0100};
    refill(hv);

    // Request together with flush: flush wins; held flush extends FLUSH
    refill_req_i = 1'b1;
    flush_i      = 1'b1;
    @(negedge clk);
    refill_req_i = 1'b0;
    chk_flush("req_flush");
    chk_b("req_flush_ready", refill_ready_o, 1'b0);
    @(negedge clk);
    flush_i = 1'b0;
    chk_b("flush_extend", flush_en_o, 1'b1);
    @(negedge clk);
    chk_idle("req_flush_idle");

    // Reset mid-refill discards everything, including the victim pointer
    refill_req_i = 1'b1;
    refill_tag_i = 20'h13579;
    refill_idx_i = 6'd21;
    @(negedge clk);
    refill_req_i = 1'b0;
    beat_valid_i = 1'b1;
    beat_data_i  = 64'hFFFF;
    @(negedge clk);
    beat_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk_b("midreset_busy", busy_o, 1'b0);
    chk_v("midreset_cline", cline_o, 256'(0));
    chk_v("midreset_tag", 256'(tag_o), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    hv = '{6'd2, 20'hEEEEE, {64'h8888888888888888, 64'h7777777777777777,
           64'h6666666666666666, 64'h5555555555555555}, 1'b1, 1'b0, 4'b0001};
    refill(hv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

endmodule
